// File: rtl/jt49_mdiv.sv
// Multi-channel PSG period divider: per-channel period register, counter, square output and toggle tick.
// Latency: div/tick update on the edge of the qualifying cen; a period write is compared at the following cen.
// Backpressure: none; cen gates counter advance, writes and sync act on every clk regardless of cen.
module jt49_mdiv #(
    parameter int W   = 12,
    parameter int CH  = 3,
    parameter int CHW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           wr,
    input  logic [CHW-1:0] wr_ch,
    input  logic [W-1:0]   wr_period,
    input  logic           wr_restart,
    input  logic [CH-1:0]  en,
    input  logic           sync,
    output logic [CH-1:0]  div,
    output logic [CH-1:0]  tick
);

    logic [W-1:0]  count  [CH];
    logic [W-1:0]  period [CH];
    logic [CH-1:0] wr_hit;

    // Decode the write target; channel numbers at or above CH never match, so such writes drop out here.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i] = wr && (wr_ch == CHW'(i));
        end
    end

    // Per-channel state: period load is independent of restart priority; phase follows sync > restart > cen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                count[i]  <= W'(1);
                period[i] <= '0;
            end
            div  <= '0;
            tick <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (wr_hit[i]) begin
                    period[i] <= wr_period;
                end

                if (sync || (wr_hit[i] && wr_restart)) begin
                    count[i] <= W'(1);
                    div[i]   <= 1'b0;
                    tick[i]  <= 1'b0;
                end else if (cen && en[i]) begin
                    // Period 0 compares like period 1, so the channel never stalls and
                    // the counter stays within max(period,1) without wrapping.
                    if (count[i] >= period[i]) begin
                        count[i] <= W'(1);
                        div[i]   <= ~div[i];
                        tick[i]  <= 1'b1;
                    end else begin
                        count[i] <= count[i] + W'(1);
                        tick[i]  <= 1'b0;
                    end
                end else begin
                    // Disabled or idle cycle: phase holds, tick lasts only one clk.
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt49_mdiv.sv
module tb_jt49_mdiv;

    localparam int W   = 12;
    localparam int CH  = 3;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cen;
    logic           wr;
    logic [CHW-1:0] wr_ch;
    logic [W-1:0]   wr_period;
    logic           wr_restart;
    logic [CH-1:0]  en;
    logic           sync;
    logic [CH-1:0]  div;
    logic [CH-1:0]  tick;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cens elapsed since the last phase restart, per channel.
    int            m_per [CH];
    int            m_el  [CH];
    logic [CH-1:0] m_div;
    logic [CH-1:0] m_tick;

    jt49_mdiv #(.W(W), .CH(CH), .CHW(CHW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .wr         (wr),
        .wr_ch      (wr_ch),
        .wr_period  (wr_period),
        .wr_restart (wr_restart),
        .en         (en),
        .sync       (sync),
        .div        (div),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_per[i] = 0;
            m_el[i]  = 0;
        end
        m_div  = '0;
        m_tick = '0;
    endtask

    // One channel toggles after max(period,1) enabled cens since its last restart.
    task automatic model_step();
        for (int i = 0; i < CH; i++) begin
            bit hit;
            int lim;
            hit = wr && (int'(wr_ch) == i);
            lim = (m_per[i] == 0) ? 1 : m_per[i];
            m_tick[i] = 1'b0;
            if (sync || (hit && wr_restart)) begin
                m_el[i]  = 0;
                m_div[i] = 1'b0;
            end else if (cen && en[i]) begin
                if (m_el[i] + 1 >= lim) begin
                    m_el[i]   = 0;
                    m_div[i]  = ~m_div[i];
                    m_tick[i] = 1'b1;
                end else begin
                    m_el[i]++;
                end
            end
            if (hit) m_per[i] = int'(wr_period);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare outputs with the model.
    task automatic cyc(input logic c, input logic w, input logic [CHW-1:0] wch,
                       input logic [W-1:0] wp, input logic wrs, input logic [CH-1:0] e,
                       input logic s);
        cen = c; wr = w; wr_ch = wch; wr_period = wp; wr_restart = wrs; en = e; sync = s;
        @(posedge clk);
        model_step();
        #1;
        chk("div", 32'(div), 32'(m_div));
        chk("tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic run(input int n, input logic c, input logic [CH-1:0] e);
        for (int k = 0; k < n; k++) cyc(c, 1'b0, '0, '0, 1'b0, e, 1'b0);
    endtask

    initial begin
        int last;
        int gaps;
        rst_n = 1'b0; cen = 1'b0; wr = 1'b0; wr_ch = '0; wr_period = '0;
        wr_restart = 1'b0; en = '0; sync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_div", 32'(div), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 period 3, cen held high: toggles on every third clk.
        cyc(1'b0, 1'b1, 2'd0, 12'd3, 1'b0, 3'b001, 1'b0);
        run(2, 1'b1, 3'b001);
        chk("p3_before", 32'(div[0]), 32'd0);
        run(1, 1'b1, 3'b001);
        chk("p3_first", 32'(div[0]), 32'd1);
        chk("p3_tick", 32'(tick[0]), 32'd1);
        run(12, 1'b1, 3'b001);
        chk("p3_others", 32'(div[2:1]), 32'd0);

        // ch1 period 2 with cen 1-in-4: toggles every 8 clks, tick one clk wide.
        cyc(1'b0, 1'b1, 2'd1, 12'd2, 1'b1, 3'b010, 1'b0);
        for (int k = 0; k < 40; k++) cyc((k % 4) == 0, 1'b0, '0, '0, 1'b0, 3'b010, 1'b0);

        // ch2 period 0: toggle every clk, tick stays high.
        cyc(1'b0, 1'b1, 2'd2, 12'd0, 1'b1, 3'b100, 1'b0);
        run(6, 1'b1, 3'b100);
        chk("p0_tick", 32'(tick[2]), 32'd1);

        // ch2 period 4095: measure toggle spacing.
        cyc(1'b0, 1'b1, 2'd2, 12'd4095, 1'b1, 3'b100, 1'b0);
        last = 0; gaps = 0;
        for (int k = 1; k <= 3 * 4095 + 10; k++) begin
            cyc(1'b1, 1'b0, '0, '0, 1'b0, 3'b100, 1'b0);
            if (tick[2]) begin
                chk("p4095_gap", 32'(k - last), 32'd4095);
                last = k;
                gaps++;
            end
        end
        chk("p4095_count", 32'(gaps), 32'd3);

        // ch0 period 10, count 7, then lower to 5 without restart: immediate toggle.
        cyc(1'b0, 1'b1, 2'd0, 12'd10, 1'b1, 3'b001, 1'b0);
        run(6, 1'b1, 3'b001);
        cyc(1'b0, 1'b1, 2'd0, 12'd5, 1'b0, 3'b001, 1'b0);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, 3'b001, 1'b0);
        chk("lower_tick", 32'(tick[0]), 32'd1);
        chk("lower_div", 32'(div[0]), 32'd1);
        run(3, 1'b1, 3'b001);
        // Restart write with cen high: restart wins, first toggle 5 cens later.
        cyc(1'b1, 1'b1, 2'd0, 12'd5, 1'b1, 3'b001, 1'b0);
        chk("restart_div", 32'(div[0]), 32'd0);
        run(4, 1'b1, 3'b001);
        chk("restart_wait", 32'(tick[0]), 32'd0);
        run(1, 1'b1, 3'b001);
        chk("restart_fire", 32'(tick[0]), 32'd1);

        // sync together with wr+restart on ch1, then an out-of-range write.
        run(5, 1'b1, 3'b111);
        cyc(1'b1, 1'b1, 2'd1, 12'd7, 1'b1, 3'b111, 1'b1);
        chk("sync_div", 32'(div), 32'd0);
        cyc(1'b1, 1'b1, 2'd3, 12'd1, 1'b1, 3'b111, 1'b0);
        run(20, 1'b1, 3'b111);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [W-1:0] p;
            p = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, CHW'($urandom_range(0, 3)),
                p, $urandom_range(0, 1) == 1, CH'($urandom), $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset between edges.
        run(3, 1'b1, 3'b111);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_div", 32'(div), 32'd0);
        chk("arst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, '0, '0, 1'b0, 3'b111, 1'b0);
        chk("post_rst_div", 32'(div), 32'd7);
        run(6, 1'b1, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
